// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, centre-of-bit sampling, one-cycle
// data-valid and framing-error strobes.
module uart_rx #(
    parameter int CLOCKS_PER_BIT = 217
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_Frame_Err,
    output logic       o_RX_Active
);

    // state     | meaning
    // IDLE      | line idle, waiting for a falling edge
    // START_BIT | timing to the centre of the start bit, rejecting glitches
    // DATA_BITS | sampling 8 data bits, LSB first, one per bit period
    // STOP_BIT  | sampling the stop bit, raising DV or framing error
    // WAIT_HIGH | line stuck low after a framing error, waiting for idle
    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT,
        WAIT_HIGH
    } state_t;

    localparam int HALF_BIT = (CLOCKS_PER_BIT - 1) / 2;
    localparam int CNT_W    = $clog2(CLOCKS_PER_BIT) + 1;

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic [2:0]       bit_idx;
    logic             rx_meta;
    logic             rx_s;

    // Both flops reset high so a reset never looks like a start edge.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_RX_Serial;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state          <= IDLE;
            counter        <= '0;
            bit_idx        <= '0;
            o_RX_DV        <= 1'b0;
            o_RX_Byte      <= 8'h00;
            o_RX_Frame_Err <= 1'b0;
            o_RX_Active    <= 1'b0;
        end else begin
            o_RX_DV        <= 1'b0;
            o_RX_Frame_Err <= 1'b0;

            case (state)
                IDLE: begin
                    counter     <= '0;
                    bit_idx     <= '0;
                    o_RX_Active <= 1'b0;
                    if (!rx_s) begin
                        state       <= START_BIT;
                        o_RX_Active <= 1'b1;
                    end
                end

                START_BIT: begin
                    if (counter == HALF_CNT) begin
                        counter <= '0;
                        if (!rx_s) begin
                            state <= DATA_BITS;
                        end else begin
                            state       <= IDLE;
                            o_RX_Active <= 1'b0;
                        end
                    end else begin
                        counter <= counter + CNT_ONE;
                    end
                end

                DATA_BITS: begin
                    if (counter == LAST_CNT) begin
                        counter            <= '0;
                        o_RX_Byte[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            state   <= STOP_BIT;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        counter <= counter + CNT_ONE;
                    end
                end

                // Leaves half a bit early so a back-to-back start edge is caught.
                STOP_BIT: begin
                    if (counter == LAST_CNT) begin
                        counter     <= '0;
                        o_RX_Active <= 1'b0;
                        if (rx_s) begin
                            o_RX_DV <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            o_RX_Frame_Err <= 1'b1;
                            state          <= WAIT_HIGH;
                        end
                    end else begin
                        counter <= counter + CNT_ONE;
                    end
                end

                WAIT_HIGH: begin
                    counter <= '0;
                    bit_idx <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state       <= IDLE;
                    counter     <= '0;
                    bit_idx     <= '0;
                    o_RX_Active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: one instance at the default bit rate, one at 16 clocks/bit,
// driven from frame-level tasks and compared against arithmetic expectations.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CPB_A  = 217;
    localparam int CPB_B  = 16;
    localparam int HALF_A = (CPB_A - 1) / 2;
    localparam int HALF_B = (CPB_B - 1) / 2;
    localparam int LAT_A  = 3 + HALF_A + 9 * CPB_A;
    localparam int LAT_B  = 3 + HALF_B + 9 * CPB_B;

    logic       clk = 1'b0;
    logic       rst_a = 1'b0, rst_b = 1'b0;
    logic       rx_a = 1'b1, rx_b = 1'b1;
    logic       dv_a, fe_a, act_a, dv_b, fe_b, act_b;
    logic [7:0] byte_a, byte_b;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] q_byte_a[$], q_byte_b[$];
    int         q_time_a[$], q_time_b[$];
    int         fe_cnt_a = 0, fe_cnt_b = 0, both_a = 0, both_b = 0;
    int         win_lo = 1, win_hi = 0, act_gap_a = 0;

    uart_rx #(.CLOCKS_PER_BIT(CPB_A)) dut_a (
        .i_Clk(clk), .i_Rst_L(rst_a), .i_RX_Serial(rx_a),
        .o_RX_DV(dv_a), .o_RX_Byte(byte_a), .o_RX_Frame_Err(fe_a), .o_RX_Active(act_a)
    );

    uart_rx #(.CLOCKS_PER_BIT(CPB_B)) dut_b (
        .i_Clk(clk), .i_Rst_L(rst_b), .i_RX_Serial(rx_b),
        .o_RX_DV(dv_b), .o_RX_Byte(byte_b), .o_RX_Frame_Err(fe_b), .o_RX_Active(act_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dv_a) begin q_byte_a.push_back(byte_a); q_time_a.push_back(cyc); end
        if (dv_b) begin q_byte_b.push_back(byte_b); q_time_b.push_back(cyc); end
        if (fe_a) fe_cnt_a++;
        if (fe_b) fe_cnt_b++;
        if (dv_a && fe_a) both_a++;
        if (dv_b && fe_b) both_b++;
        if (cyc >= win_lo && cyc <= win_hi && !act_a) act_gap_a++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic drive_bit(input bit sel, input logic v, input int n);
        if (sel) rx_b = v; else rx_a = v;
        repeat (n) @(negedge clk);
    endtask

    // Called on a negedge; E0 is the next rising edge, which samples the start bit.
    task automatic send_frame(input bit sel, input logic [7:0] data, input logic stop,
                              output int e0);
        int cpb;
        cpb = sel ? CPB_B : CPB_A;
        e0 = cyc + 1;
        drive_bit(sel, 1'b0, cpb);
        for (int i = 0; i < 8; i++) drive_bit(sel, data[i], cpb);
        drive_bit(sel, stop, cpb);
    endtask

    task automatic clear_a();
        q_byte_a.delete(); q_time_a.delete(); fe_cnt_a = 0;
    endtask

    task automatic clear_b();
        q_byte_b.delete(); q_time_b.delete(); fe_cnt_b = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_tests++;
        if ({dv_a, byte_a, fe_a, act_a} !== 11'h000) begin
            n_fail++; $display("FAIL reset_a: outputs=%h required 000", {dv_a, byte_a, fe_a, act_a});
        end
        n_tests++;
        if ({dv_b, byte_b, fe_b, act_b} !== 11'h000) begin
            n_fail++; $display("FAIL reset_b: outputs=%h required 000", {dv_b, byte_b, fe_b, act_b});
        end
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (2 * CPB_B) @(negedge clk);
        n_tests++;
        if ({dv_a, byte_a, fe_a, act_a} !== 11'h000) begin
            n_fail++; $display("FAIL idle_after_reset_a: outputs=%h required 000", {dv_a, byte_a, fe_a, act_a});
        end
        n_tests++;
        if ({dv_b, byte_b, fe_b, act_b} !== 11'h000) begin
            n_fail++; $display("FAIL idle_after_reset_b: outputs=%h required 000", {dv_b, byte_b, fe_b, act_b});
        end
    endtask

    task automatic test_single_frame();
        int e0;
        clear_a(); act_gap_a = 0;
        win_lo = cyc + 1 + 2;
        win_hi = cyc + 1 + 2 + HALF_A + 9 * CPB_A;
        send_frame(1'b0, 8'hA5, 1'b1, e0);
        repeat (2 * CPB_A) @(negedge clk);
        win_lo = 1; win_hi = 0;
        n_tests++;
        if (q_byte_a.size() != 1) begin
            n_fail++; $display("FAIL single_dv_count: got %0d required 1", q_byte_a.size());
        end else begin
            n_tests++;
            if (q_byte_a[0] !== 8'hA5) begin
                n_fail++; $display("FAIL single_byte: got %h required a5", q_byte_a[0]);
            end
            n_tests++;
            if (q_time_a[0] != e0 + LAT_A) begin
                n_fail++; $display("FAIL single_latency: got %0d required %0d", q_time_a[0] - e0, LAT_A);
            end
        end
        n_tests++;
        if (fe_cnt_a != 0) begin
            n_fail++; $display("FAIL single_frame_err: got %0d pulses required 0", fe_cnt_a);
        end
        n_tests++;
        if (act_gap_a != 0) begin
            n_fail++; $display("FAIL single_active: active low for %0d cycles in frame, required 0", act_gap_a);
        end
        n_tests++;
        if (act_a !== 1'b0) begin
            n_fail++; $display("FAIL single_active_end: got %b required 0", act_a);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b[3];
        int         e0s[3];
        int         e0;
        exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h3C;
        clear_a();
        for (int i = 0; i < 3; i++) begin
            send_frame(1'b0, exp_b[i], 1'b1, e0);
            e0s[i] = e0;
        end
        repeat (2 * CPB_A) @(negedge clk);
        n_tests++;
        if (q_byte_a.size() != 3) begin
            n_fail++; $display("FAIL b2b_dv_count: got %0d required 3", q_byte_a.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (q_byte_a[i] !== exp_b[i]) begin
                    n_fail++; $display("FAIL b2b_byte%0d: got %h required %h", i, q_byte_a[i], exp_b[i]);
                end
                n_tests++;
                if (q_time_a[i] != e0s[i] + LAT_A) begin
                    n_fail++; $display("FAIL b2b_latency%0d: got %0d required %0d", i, q_time_a[i] - e0s[i], LAT_A);
                end
            end
        end
        n_tests++;
        if (fe_cnt_a != 0 || both_a != 0) begin
            n_fail++; $display("FAIL b2b_frame_err: got %0d errors, %0d overlaps, required 0", fe_cnt_a, both_a);
        end
    endtask

    task automatic test_glitch();
        int e0;
        clear_a();
        e0 = cyc + 1;
        drive_bit(1'b0, 1'b0, 4);
        n_tests++;
        if (act_a !== 1'b1) begin
            n_fail++; $display("FAIL glitch_active_rise: got %b required 1", act_a);
        end
        drive_bit(1'b0, 1'b0, 16);
        drive_bit(1'b0, 1'b1, HALF_A + 5 - 20);
        n_tests++;
        if (act_a !== 1'b0) begin
            n_fail++; $display("FAIL glitch_active_drop: got %b required 0 at E0+%0d", act_a, cyc - e0);
        end
        repeat (12 * CPB_A) @(negedge clk);
        n_tests++;
        if (q_byte_a.size() != 0 || fe_cnt_a != 0) begin
            n_fail++; $display("FAIL glitch_silent: got %0d strobes %0d errors required 0 0", q_byte_a.size(), fe_cnt_a);
        end
        send_frame(1'b0, 8'h5A, 1'b1, e0);
        repeat (CPB_A) @(negedge clk);
        n_tests++;
        if (q_byte_a.size() != 1 || q_byte_a[0] !== 8'h5A || q_time_a[0] != e0 + LAT_A) begin
            n_fail++; $display("FAIL glitch_next_frame: got %0d strobes first=%h required 1 strobe 5a at E0+%0d",
                               q_byte_a.size(), (q_byte_a.size() > 0) ? q_byte_a[0] : 8'hxx, LAT_A);
        end
    endtask

    task automatic test_framing_error();
        int e0;
        clear_a();
        send_frame(1'b0, 8'h81, 1'b0, e0);
        drive_bit(1'b0, 1'b0, 5 * CPB_A);
        n_tests++;
        if (fe_cnt_a != 1) begin
            n_fail++; $display("FAIL ferr_count: got %0d pulses required 1", fe_cnt_a);
        end
        n_tests++;
        if (q_byte_a.size() != 0) begin
            n_fail++; $display("FAIL ferr_no_dv: got %0d strobes required 0", q_byte_a.size());
        end
        drive_bit(1'b0, 1'b1, 2 * CPB_A);
        send_frame(1'b0, 8'h42, 1'b1, e0);
        repeat (CPB_A) @(negedge clk);
        n_tests++;
        if (q_byte_a.size() != 1 || q_byte_a[0] !== 8'h42 || q_time_a[0] != e0 + LAT_A) begin
            n_fail++; $display("FAIL ferr_recover: got %0d strobes first=%h required 1 strobe 42 at E0+%0d",
                               q_byte_a.size(), (q_byte_a.size() > 0) ? q_byte_a[0] : 8'hxx, LAT_A);
        end
        n_tests++;
        if (fe_cnt_a != 1 || both_a != 0) begin
            n_fail++; $display("FAIL ferr_total: got %0d errors %0d overlaps required 1 0", fe_cnt_a, both_a);
        end
    endtask

    task automatic test_reset_mid_frame();
        int         e0;
        logic [7:0] part;
        part = 8'h0F;
        clear_a();
        drive_bit(1'b0, 1'b0, CPB_A);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, part[i], CPB_A);
        drive_bit(1'b0, part[4], CPB_A / 2);
        n_tests++;
        if (act_a !== 1'b1 || byte_a[3:0] !== 4'hF) begin
            n_fail++; $display("FAIL pre_reset: active=%b low_nibble=%h required 1 f", act_a, byte_a[3:0]);
        end
        rx_a = 1'b1;
        rst_a = 1'b0;
        #1;
        n_tests++;
        if ({dv_a, byte_a, fe_a, act_a} !== 11'h000) begin
            n_fail++; $display("FAIL mid_reset_async: outputs=%h required 000", {dv_a, byte_a, fe_a, act_a});
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if ({dv_a, byte_a, fe_a, act_a} !== 11'h000) begin
            n_fail++; $display("FAIL mid_reset_held: outputs=%h required 000", {dv_a, byte_a, fe_a, act_a});
        end
        rst_a = 1'b1;
        repeat (10 * CPB_A) @(negedge clk);
        n_tests++;
        if (q_byte_a.size() != 0 || fe_cnt_a != 0 || byte_a !== 8'h00) begin
            n_fail++; $display("FAIL aborted_frame: got %0d strobes %0d errors byte=%h required 0 0 00",
                               q_byte_a.size(), fe_cnt_a, byte_a);
        end
        send_frame(1'b0, 8'hC3, 1'b1, e0);
        repeat (CPB_A) @(negedge clk);
        n_tests++;
        if (q_byte_a.size() != 1 || q_byte_a[0] !== 8'hC3 || q_time_a[0] != e0 + LAT_A) begin
            n_fail++; $display("FAIL post_reset_frame: got %0d strobes first=%h required 1 strobe c3 at E0+%0d",
                               q_byte_a.size(), (q_byte_a.size() > 0) ? q_byte_a[0] : 8'hxx, LAT_A);
        end
    endtask

    task automatic test_fast_rate();
        int e0;
        clear_b();
        send_frame(1'b1, 8'h96, 1'b1, e0);
        repeat (2 * CPB_B) @(negedge clk);
        n_tests++;
        if (q_byte_b.size() != 1) begin
            n_fail++; $display("FAIL fast_dv_count: got %0d required 1", q_byte_b.size());
        end else begin
            n_tests++;
            if (q_byte_b[0] !== 8'h96) begin
                n_fail++; $display("FAIL fast_byte: got %h required 96", q_byte_b[0]);
            end
            n_tests++;
            if (q_time_b[0] != e0 + 154) begin
                n_fail++; $display("FAIL fast_latency: got %0d required 154", q_time_b[0] - e0);
            end
        end
    endtask

    task automatic test_random_frames();
        logic [7:0] exp_q[$];
        int         exp_t[$];
        logic [7:0] d;
        int         e0;
        clear_b();
        for (int i = 0; i < 8; i++) begin
            drive_bit(1'b1, 1'b1, $urandom_range(0, 20));
            d = 8'($urandom);
            send_frame(1'b1, d, 1'b1, e0);
            exp_q.push_back(d);
            exp_t.push_back(e0 + LAT_B);
        end
        repeat (3 * CPB_B) @(negedge clk);
        n_tests++;
        if (q_byte_b.size() != exp_q.size()) begin
            n_fail++; $display("FAIL rand_dv_count: got %0d required %0d", q_byte_b.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_tests++;
                if (q_byte_b[i] !== exp_q[i] || q_time_b[i] != exp_t[i]) begin
                    n_fail++; $display("FAIL rand_frame%0d: got %h at %0d required %h at %0d",
                                       i, q_byte_b[i], q_time_b[i], exp_q[i], exp_t[i]);
                end
            end
        end
        n_tests++;
        if (fe_cnt_b != 0 || both_b != 0) begin
            n_fail++; $display("FAIL rand_frame_err: got %0d errors %0d overlaps required 0 0", fe_cnt_b, both_b);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_glitch();
        test_framing_error();
        test_reset_mid_frame();
        test_fast_rate();
        test_random_frames();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
